commutator_ctrl: RTL and testbench



---
 rtl/commutator_ctrl.sv | 107 ++++++++++
 tb/tb_commutator_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/commutator_ctrl.sv
// Sequencing controller for one delay-commutator FFT stage: tracks input
// framing, drives the commutator select in step with the free-running delay
// buffers, regenerates output framing and flags gap/restart violations.
module commutator_ctrl #(
  parameter int DEPTH = 4,
  parameter int FRAME = 16,
  parameter int CW    = $clog2(FRAME)   // derived; leave at default
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic in_sop,
  output logic sw_sel,
  output logic out_valid,
  output logic out_sop,
  output logic out_eop,
  output logic frame_done,
  output logic busy,
  output logic err_gap,
  output logic err_sop
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  // Bit of the sample index that toggles every DEPTH samples.
  localparam int unsigned SB = $clog2(DEPTH);
  localparam logic [CW-1:0] LAST = CW'(FRAME - 1);

  logic [0:0]    state, state_n;
  logic [CW-1:0] idx, idx_n;

  // Tag pipe: one bit-vector per field, stage 0 is the newest entry.
  logic [DEPTH:0] pv, ps, pe;

  logic          acc, gap, restart;
  logic [CW-1:0] k;

  // Input framing decisions for the current cycle.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    acc     = 1'b0;
    gap     = 1'b0;
    restart = 1'b0;
    k       = '0;
    if (state == IDLE) begin
      if (in_valid && in_sop) begin
        acc     = 1'b1;
        idx_n   = CW'(1);
        state_n = RUN;
      end
    end else begin
      if (in_valid && in_sop) begin
        restart = 1'b1;
        acc     = 1'b1;
        idx_n   = CW'(1);
      end else if (in_valid) begin
        acc = 1'b1;
        k   = idx;
        if (idx == LAST) begin
          idx_n   = '0;
          state_n = IDLE;
        end else begin
          idx_n = idx + CW'(1);
        end
      end else begin
        gap     = 1'b1;
        idx_n   = '0;
        state_n = IDLE;
      end
    end
  end

  // State, select, tag pipe and error pulses.
  // An abort clears every older tag but still loads the restart sample's tag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      idx     <= '0;
      sw_sel  <= 1'b0;
      pv      <= '0;
      ps      <= '0;
      pe      <= '0;
      err_gap <= 1'b0;
      err_sop <= 1'b0;
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      err_gap <= gap;
      err_sop <= restart;
      if (acc) begin
        sw_sel <= k[SB];
      end
      pv <= {pv[DEPTH-1:0] & {DEPTH{~(gap | restart)}}, acc};
      ps <= {ps[DEPTH-1:0] & {DEPTH{~(gap | restart)}}, acc & (k == '0)};
      pe <= {pe[DEPTH-1:0] & {DEPTH{~(gap | restart)}}, acc & (k == LAST)};
    end
  end

  assign out_valid  = pv[DEPTH];
  assign out_sop    = ps[DEPTH];
  assign out_eop    = pe[DEPTH];
  assign frame_done = pe[DEPTH];
  assign busy       = (state == RUN) | (|pv);

endmodule

// File: tb/tb_commutator_ctrl.sv
// Self-checking bench for commutator_ctrl against a cycle-schedule model.
module tb_commutator_ctrl;

  localparam int DEPTH = 4;
  localparam int FRAME = 16;
  localparam int R     = 32;

  logic clk = 1'b0;
  logic rst, in_valid, in_sop;
  logic sw_sel, out_valid, out_sop, out_eop, frame_done, busy, err_gap, err_sop;

  always #5 clk = ~clk;

  commutator_ctrl #(.DEPTH(DEPTH), .FRAME(FRAME)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_sop(in_sop),
    .sw_sel(sw_sel), .out_valid(out_valid), .out_sop(out_sop),
    .out_eop(out_eop), .frame_done(frame_done), .busy(busy),
    .err_gap(err_gap), .err_sop(err_sop)
  );

  logic [7:0] obs;
  assign obs = {sw_sel, out_valid, out_sop, out_eop, frame_done, busy, err_gap, err_sop};

  int n_tests = 0;
  int n_fail  = 0;
  int gcyc    = 0;

  // Model: frame tracking plus a schedule of output tags by future cycle.
  bit   m_run = 1'b0;
  int   m_idx = 0;
  bit   m_sw  = 1'b0;
  bit   sv[R], ss[R], se[R];
  logic [7:0] exp_vec;

  // Drive one cycle of inputs, advance the model, wait for the edge.
  task automatic step(input bit v, input bit s, input bit r);
    int n, k;
    bit gp, rs, acc, bz;
    in_valid = v;
    in_sop   = s;
    rst      = r;
    n = gcyc; k = 0; gp = 0; rs = 0; acc = 0;
    if (r) begin
      m_run = 0; m_idx = 0; m_sw = 0;
      for (int i = 0; i < R; i++) begin sv[i] = 0; ss[i] = 0; se[i] = 0; end
    end else begin
      if (!m_run) begin
        if (v && s) begin acc = 1; k = 0; m_run = 1; m_idx = 1; end
      end else if (v && s) begin
        rs = 1;
        for (int i = 1; i <= DEPTH + 1; i++) begin
          sv[(n+i)%R] = 0; ss[(n+i)%R] = 0; se[(n+i)%R] = 0;
        end
        acc = 1; k = 0; m_idx = 1;
      end else if (v) begin
        acc = 1; k = m_idx;
        if (k == FRAME - 1) begin m_run = 0; m_idx = 0; end
        else m_idx = m_idx + 1;
      end else begin
        gp = 1;
        for (int i = 1; i <= DEPTH + 1; i++) begin
          sv[(n+i)%R] = 0; ss[(n+i)%R] = 0; se[(n+i)%R] = 0;
        end
        m_run = 0; m_idx = 0;
      end
      if (acc) begin
        m_sw = ((k / DEPTH) % 2) == 1;
        sv[(n+DEPTH+1)%R] = 1;
        ss[(n+DEPTH+1)%R] = (k == 0);
        se[(n+DEPTH+1)%R] = (k == FRAME - 1);
      end
    end
    bz = m_run;
    for (int i = 1; i <= DEPTH + 1; i++) bz |= sv[(n+i)%R];
    exp_vec = {m_sw, sv[(n+1)%R], ss[(n+1)%R], se[(n+1)%R], se[(n+1)%R], bz, gp, rs};
    sv[(n+1)%R] = 0; ss[(n+1)%R] = 0; se[(n+1)%R] = 0;
    @(posedge clk);
    #1;
    gcyc++;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, i < 3);
      n_tests++;
      if (obs !== exp_vec) begin
        n_fail++;
        $display("FAIL reset cyc=%0d got=%b want=%b", gcyc, obs, exp_vec);
      end
    end
  endtask

  task automatic test_single_frame();
    int sop_at = -1, eop_at = -1, busy_low = -1;
    for (int i = -2; i < FRAME + DEPTH + 4; i++) begin
      step(i >= 0 && i < FRAME, i == 0, 1'b0);
      n_tests++;
      if (obs !== exp_vec) begin
        n_fail++;
        $display("FAIL single_frame cyc=%0d got=%b want=%b", gcyc, obs, exp_vec);
      end
      if (i >= 0) begin
        if (out_sop && sop_at < 0) sop_at = i + 1;
        if (out_eop && eop_at < 0) eop_at = i + 1;
        if (!busy && i + 1 > 1 && busy_low < 0) busy_low = i + 1;
      end
    end
    n_tests++;
    if (sop_at !== 5 || eop_at !== 20 || busy_low !== 21) begin
      n_fail++;
      $display("FAIL single_frame_timing got sop=%0d eop=%0d busy_low=%0d want 5 20 21",
               sop_at, eop_at, busy_low);
    end
  endtask

  task automatic test_back_to_back();
    int n_eop = 0, n_val = 0, sw17 = -1;
    for (int i = 0; i < 2*FRAME + DEPTH + 4; i++) begin
      step(i < 2*FRAME, i == 0 || i == FRAME, 1'b0);
      n_tests++;
      if (obs !== exp_vec) begin
        n_fail++;
        $display("FAIL back_to_back cyc=%0d got=%b want=%b", gcyc, obs, exp_vec);
      end
      if (out_eop) n_eop++;
      if (out_valid && i + 1 >= 5 && i + 1 <= 36) n_val++;
      if (i + 1 == 17) sw17 = sw_sel;
    end
    n_tests++;
    if (n_eop !== 2 || n_val !== 32 || sw17 !== 0) begin
      n_fail++;
      $display("FAIL back_to_back_framing got eop=%0d valid=%0d sw17=%0d want 2 32 0",
               n_eop, n_val, sw17);
    end
  endtask

  task automatic test_gap();
    int gap_at = -1, n_eop = 0, busy8 = -1;
    for (int i = 0; i < 20; i++) begin
      step(i < 7, i == 0, 1'b0);
      n_tests++;
      if (obs !== exp_vec) begin
        n_fail++;
        $display("FAIL gap cyc=%0d got=%b want=%b", gcyc, obs, exp_vec);
      end
      if (err_gap && gap_at < 0) gap_at = i + 1;
      if (out_eop) n_eop++;
      if (i + 1 == 8) busy8 = busy;
    end
    n_tests++;
    if (gap_at !== 8 || n_eop !== 0 || busy8 !== 0) begin
      n_fail++;
      $display("FAIL gap_abort got err_gap_at=%0d eop=%0d busy8=%0d want 8 0 0",
               gap_at, n_eop, busy8);
    end
  endtask

  task automatic test_restart();
    bit esop7 = 0, sop11 = 0, eop26 = 0, sw7 = 1;
    for (int i = 0; i < 32; i++) begin
      step(i < 22, i == 0 || i == 6, 1'b0);
      n_tests++;
      if (obs !== exp_vec) begin
        n_fail++;
        $display("FAIL restart cyc=%0d got=%b want=%b", gcyc, obs, exp_vec);
      end
      if (i + 1 == 7)  begin esop7 = err_sop; sw7 = sw_sel; end
      if (i + 1 == 11) sop11 = out_sop;
      if (i + 1 == 26) eop26 = out_eop;
    end
    n_tests++;
    if (!esop7 || !sop11 || !eop26 || sw7) begin
      n_fail++;
      $display("FAIL restart_framing got esop7=%0d sop11=%0d eop26=%0d sw7=%0d want 1 1 1 0",
               esop7, sop11, eop26, sw7);
    end
  endtask

  task automatic test_mid_reset();
    int n_out = 0;
    for (int i = 0; i < 24; i++) begin
      step(i <= 10 || (i >= 12 && i <= 15), i == 0, i == 10);
      n_tests++;
      if (obs !== exp_vec) begin
        n_fail++;
        $display("FAIL mid_reset cyc=%0d got=%b want=%b", gcyc, obs, exp_vec);
      end
      if (i + 1 == 11 && obs !== 8'h00) begin
        n_fail++;
        $display("FAIL mid_reset_zero got=%b want=00000000", obs);
      end
      if (i + 1 >= 11 && out_valid) n_out++;
    end
    n_tests++;
    if (n_out !== 0) begin
      n_fail++;
      $display("FAIL mid_reset_quiet got out_valid_cycles=%0d want 0", n_out);
    end
  endtask

  task automatic test_idle_noise();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 1'b0);
      n_tests++;
      if (obs !== exp_vec || obs !== 8'h00) begin
        n_fail++;
        $display("FAIL idle_noise cyc=%0d got=%b want=%b", gcyc, obs, exp_vec);
      end
    end
  endtask

  task automatic test_random();
    bit v, s, r;
    for (int i = 0; i < 1500; i++) begin
      r = ($urandom_range(0, 199) == 0);
      v = ($urandom_range(0, 99) < 96);
      s = v && ($urandom_range(0, 99) < (m_run ? 3 : 50));
      step(v, s, r);
      n_tests++;
      if (obs !== exp_vec) begin
        n_fail++;
        $display("FAIL random cyc=%0d got=%b want=%b", gcyc, obs, exp_vec);
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sop = 1'b0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_gap();
    test_restart();
    test_mid_reset();
    test_idle_noise();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
